// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer of {pc, instr} entries; push/pop same cycle allowed, flush empties it.
// Head is visible the cycle after push; push into a full buffer without a pop is an overflow.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [31:0]     push_pc,
  input  logic [31:0]     push_instr,
  input  logic            pop,
  input  logic            flush,
  output logic [CW-1:0]   count,
  output logic [31:0]     head_pc,
  output logic [31:0]     head_instr
);
  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_pop;
  logic            full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop     = pop && (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
  end

  // Issue throttling upstream must make this unreachable.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) assert (do_pop || !full);
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, ROM request issue, redirect flush; 2-cycle request-to-instr_valid latency.
// Issue stalls when buffered plus in-flight entries reach DEPTH; instr_ready never gates mem_enable.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_enable,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [31:0]     head_pc;
  logic [31:0]     head_instr;

  assign mem_enable  = !reset && !branch_valid && ((32'(count) + 32'(inflight)) < 32'(DEPTH));
  assign mem_address = pc;

  assign instr_valid = !reset && (count != '0);
  assign instr       = instr_valid ? head_instr : '0;
  assign instr_pc    = instr_valid ? head_pc : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC & ~32'h3;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (branch_valid) begin
      // Any response returning next cycle belongs to the wrong path.
      pc       <= branch_target & ~32'h3;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_enable;
      if (mem_enable) begin
        pc          <= pc + XLEN'(INSTR_BYTES);
        inflight_pc <= pc;
      end
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .push_pc    (inflight_pc),
    .push_instr (mem_data),
    .pop        (instr_valid && instr_ready),
    .flush      (branch_valid),
    .count      (count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected {pc,instr}; a monitor checks each handshake.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_en, a_branch, a_valid, a_ready;
  logic [31:0] a_addr, a_data, a_target, a_instr, a_pc;
  logic        b_en, b_valid;
  logic [31:0] b_addr, b_data, b_instr, b_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(3)) dut_a (
    .clk(clk), .reset(reset), .mem_enable(a_en), .mem_address(a_addr), .mem_data(a_data),
    .branch_valid(a_branch), .branch_target(a_target), .instr_valid(a_valid),
    .instr(a_instr), .instr_pc(a_pc), .instr_ready(a_ready));

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .mem_enable(b_en), .mem_address(b_addr), .mem_data(b_data),
    .branch_valid(1'b0), .branch_target(32'h0), .instr_valid(b_valid),
    .instr(b_instr), .instr_pc(b_pc), .instr_ready(1'b1));

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a < 32'd16) begin
      case (a[3:2])
        2'd0:    return 32'h11;
        2'd1:    return 32'h22;
        2'd2:    return 32'h33;
        default: return 32'h44;
      endcase
    end
    return a ^ 32'h5A00_0000;
  endfunction

  // Garbage when idle so a design that samples mem_data without a request shows up.
  always @(posedge clk) a_data <= a_en ? rom(a_addr) : 32'hDEAD_BEEF;
  always @(posedge clk) b_data <= b_en ? rom(b_addr) : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail = 0;
  fetch_entry_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back('{pc: pc, instr: ins});
  endtask

  always @(negedge clk) begin
    if (a_valid && a_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got pc %h instr %h with empty scoreboard at %0t", a_pc, a_instr, $time);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        chk("pop_pc", a_pc, e.pc);
        chk("pop_instr", a_instr, e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    a_branch = 1'b0;
    tick();
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_enable", 32'(a_en), 32'd0);
    chk("rst_instr", a_instr, 32'd0);
    chk("rst_instr_pc", a_pc, 32'd0);
    exp_q.delete();
    tick();
    a_ready = rdy;
    reset = 1'b0;
    #1;
  endtask

  logic [31:0] b_seq [3];
  logic [31:0] b_ins [3];
  int en_cnt;

  initial begin
    a_branch = 1'b0;
    a_target = 32'h0;
    a_ready = 1'b1;
    b_seq[0] = 32'hFFFF_FFF8; b_seq[1] = 32'hFFFF_FFFC; b_seq[2] = 32'h0000_0000;
    b_ins[0] = 32'hA5FF_FFF8; b_ins[1] = 32'hA5FF_FFFC; b_ins[2] = 32'h0000_0011;

    // Sequential fetch; dut_b wraps through the top of the address space.
    do_reset(1'b1);
    expect_entry(32'h0, 32'h11); expect_entry(32'h4, 32'h22);
    expect_entry(32'h8, 32'h33); expect_entry(32'hC, 32'h44);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        chk("seq_enable", 32'(a_en), 32'd1);
        chk("seq_addr", a_addr, 32'(4 * i));
      end
      chk("seq_valid", 32'(a_valid), (i >= 2) ? 32'd1 : 32'd0);
      if (i < 3) chk("wrap_addr", b_addr, b_seq[i]);
      if (i >= 2 && i < 5) begin
        chk("wrap_pc", b_pc, b_seq[i-2]);
        chk("wrap_instr", b_instr, b_ins[i-2]);
      end
      tick();
    end
    chk("seq_drain", 32'(exp_q.size()), 32'd0);

    // Decode stalled: exactly DEPTH requests, head held, then in-order release.
    do_reset(1'b0);
    expect_entry(32'h0, 32'h11); expect_entry(32'h4, 32'h22);
    expect_entry(32'h8, 32'h33); expect_entry(32'hC, 32'h44);
    expect_entry(32'h10, 32'h5A00_0010); expect_entry(32'h14, 32'h5A00_0014);
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      en_cnt += int'(a_en);
      if (i >= 2) begin
        chk("stall_valid", 32'(a_valid), 32'd1);
        chk("stall_head_pc", a_pc, 32'h0);
        chk("stall_head_instr", a_instr, 32'h11);
      end
      tick();
    end
    chk("stall_issues", 32'(en_cnt), 32'd3);
    a_ready = 1'b1;
    #1;
    chk("full_no_issue", 32'(a_en), 32'd0);
    tick();
    chk("resume_enable", 32'(a_en), 32'd1);
    chk("resume_addr", a_addr, 32'hC);
    repeat (4) tick();
    chk("stall_drain", 32'(exp_q.size()), 32'd1);

    // Redirects: wrong-path drop, unaligned target, back-to-back branches.
    do_reset(1'b1);
    expect_entry(32'h0, 32'h11); expect_entry(32'h4, 32'h22);
    expect_entry(32'h100, 32'h5A00_0100); expect_entry(32'h104, 32'h5A00_0104);
    expect_entry(32'h200, 32'h5A00_0200); expect_entry(32'h204, 32'h5A00_0204);
    expect_entry(32'h400, 32'h5A00_0400); expect_entry(32'h404, 32'h5A00_0404);
    expect_entry(32'h408, 32'h5A00_0408); expect_entry(32'h40C, 32'h5A00_040C);
    chk("br_addr0", a_addr, 32'h0);
    tick(); tick();
    chk("br_addr8", a_addr, 32'h8);
    tick();
    a_branch = 1'b1; a_target = 32'h100; #1;
    chk("br_cycle_enable", 32'(a_en), 32'd0);
    tick();
    a_branch = 1'b0; #1;
    chk("br_target_enable", 32'(a_en), 32'd1);
    chk("br_target_addr", a_addr, 32'h100);
    chk("br_flushed_valid", 32'(a_valid), 32'd0);
    tick();
    chk("br_gap_valid", 32'(a_valid), 32'd0);
    tick();
    chk("br_first_pc", a_pc, 32'h100);
    tick();
    a_branch = 1'b1; a_target = 32'h203;
    tick();
    a_branch = 1'b0; #1;
    chk("br_align_addr", a_addr, 32'h200);
    tick(); tick();
    chk("br_align_pc", a_pc, 32'h200);
    tick();
    a_branch = 1'b1; a_target = 32'h300;
    tick();
    a_target = 32'h400; #1;
    chk("br2_enable", 32'(a_en), 32'd0);
    tick();
    a_branch = 1'b0; #1;
    chk("br2_last_wins", a_addr, 32'h400);
    repeat (5) tick();
    chk("br_drain", 32'(exp_q.size()), 32'd1);

    // Reset with two buffered entries and one in flight.
    do_reset(1'b0);
    repeat (3) tick();
    chk("mid_valid", 32'(a_valid), 32'd1);
    chk("mid_enable", 32'(a_en), 32'd0);
    reset = 1'b1; #1;
    chk("mid_rst_valid", 32'(a_valid), 32'd0);
    chk("mid_rst_enable", 32'(a_en), 32'd0);
    do_reset(1'b1);
    expect_entry(32'h0, 32'h11); expect_entry(32'h4, 32'h22);
    expect_entry(32'h8, 32'h33); expect_entry(32'hC, 32'h44);
    expect_entry(32'h10, 32'h5A00_0010); expect_entry(32'h14, 32'h5A00_0014);
    chk("restart_addr", a_addr, 32'h0);
    chk("restart_valid", 32'(a_valid), 32'd0);
    repeat (6) tick();
    reset = 1'b1;
    chk("restart_drain", 32'(exp_q.size()), 32'd2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch initiator; sits between the decode stage and the synchronous instruction ROM.
- Owns the program counter and issues word-aligned read requests to the ROM, which returns data one cycle after enable.
- Buffers returned words with their PC and hands them to decode over a valid/ready handshake.
- Accepts branch redirects from execute; flushes wrong-path requests and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 3, instruction buffer entries (minimum 2); DEPTH >= 3 gives one instruction per cycle with no ready-to-enable combinational path.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_enable  output  1  read request to ROM this cycle.
- mem_address  output  32  byte address of request; bits [1:0] always 0.
- mem_data  input  32  ROM read data, valid the cycle after the request; little-endian word.
- branch_valid  input  1  redirect request from execute.
- branch_target  input  32  redirect byte address.
- instr_valid  output  1  buffer head holds a valid instruction.
- instr  output  32  instruction word at buffer head.
- instr_pc  output  32  byte address of instr.
- instr_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (sampled at clk edge): pc <= RESET_PC, buffer empty, inflight <= 0. Outputs during and after reset cycle: mem_enable=0, instr_valid=0, instr=0, instr_pc=0. Reset mid-operation discards all buffered and in-flight state.
- mem_enable = !reset && !branch_valid && (count + inflight < DEPTH); mem_address = pc. Both are combinational from registered state plus reset/branch_valid only. No dependency on instr_ready.
- On an issue edge: pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0). inflight <= 1 and inflight_pc <= pc.
- Response: when inflight = 1 the entry {inflight_pc, mem_data} is pushed at the next edge. mem_data is ignored when inflight = 0.
- Timing: request in cycle N, mem_data valid in N+1, captured at end of N+1, instr_valid in N+2. Steady-state throughput is 1 instruction/cycle with instr_ready held high.
- Handshake: a pop occurs when instr_valid && instr_ready. While instr_valid=1 and not popped, instr and instr_pc are held stable. Simultaneous push and pop is allowed, including at count = DEPTH-1 and count = DEPTH.
- The issue rule guarantees no push into a full buffer. Overflow is an assertion failure.
- Redirect (branch_valid=1 at edge, reset=0):
  - pc <= {branch_target[31:2], 2'b00}.
  - Buffer cleared; inflight <= 0, so the response arriving next cycle is dropped.
  - mem_enable=0 during the redirect cycle.
  - The first target request issues the following cycle; its instruction appears 2 cycles after that.
  - A pop in the same cycle as a redirect is a completed transfer.
- Branch on consecutive cycles: the last one wins.
- Reset has priority over branch_valid.
- Buffer: circular, rd/wr pointers mod DEPTH, count 0..DEPTH. Full when count = DEPTH, empty when count = 0.

Decomposition:
- Package fetch_pkg holds: XLEN=32, INSTR_BYTES=4, the default RESET_PC constant, and the typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_buffer: parameterised-depth FIFO of fetch_entry_t with push, pop, flush, count, and head outputs.
- fetch_unit holds the PC, inflight tracking, issue logic and redirect logic.

Test Plan:
- Reset with RESET_PC=0, ROM words 0..3 = 0x11,0x22,0x33,0x44, instr_ready=1 -> mem_address 0,4,8,12 on consecutive cycles. instr_valid rises 2 cycles after the first request, then instr/instr_pc = 0x11/0, 0x22/4, 0x33/8, 0x44/12 on 4 consecutive cycles.
- Hold instr_ready=0 from start -> exactly DEPTH (3) requests issue, then mem_enable=0. Head stays 0x11/0. Releasing ready delivers all 3 in order with no duplicate or loss, and issue resumes.
- Branch to 0x100 in the cycle after the request to 0x8 -> the response for 0x8 is dropped and the buffer is flushed. Next request is 0x100. The first post-branch instr_pc is 0x100.
- Branch target 0x203 -> mem_address 0x200; instr_pc 0x200.
- RESET_PC=32'hFFFF_FFF8 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000 with no X and correct instr_pc values.
- Reset asserted while count=2 and inflight=1 -> next cycle instr_valid=0 and mem_enable=0. After release, fetch restarts at RESET_PC with no stale entries.
